// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. It holds the fetch index, a write-loadable
// instruction memory and a small prefetch FIFO feeding decode through a
// valid/ready handshake. A PC-relative branch, taken against the head entry,
// flushes the FIFO and any read in flight, then restarts fetch at the target.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous reset, active-high
//   write_enable             memory write strobe
//   write_instruction_index  write address (low log2(MEM_DEPTH) bits used)
//   write_instruction        write data
//   branch_valid             redirect request, relative to the head entry
//   delta_i                  signed branch offset, in instructions
//   out_valid                head entry present
//   out_ready                decode accepts the head entry
//   out_instruction          head instruction, 0 when out_valid = 0
//   out_index                head instruction index, 0 when out_valid = 0
//   count                    FIFO occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int INSTR_W     = 16,
    parameter int INDEX_W     = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [INDEX_W-1:0] RESET_INDEX = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                write_enable,
    input  logic [INDEX_W-1:0]                  write_instruction_index,
    input  logic [INSTR_W-1:0]                  write_instruction,
    input  logic                                branch_valid,
    input  logic [INDEX_W-1:0]                  delta_i,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [INSTR_W-1:0]                  out_instruction,
    output logic [INDEX_W-1:0]                  out_index,
    output logic [$clog2(QUEUE_DEPTH):0]        count
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(QUEUE_DEPTH);

    // Instruction store and its registered read port.
    logic [INSTR_W-1:0] mem [MEM_DEPTH];
    logic [INSTR_W-1:0] rd_data_q;

    // Prefetch FIFO storage; only the pointers and occupancy are reset.
    logic [INSTR_W-1:0] fifo_instr [QUEUE_DEPTH];
    logic [INDEX_W-1:0] fifo_index [QUEUE_DEPTH];

    logic [INDEX_W-1:0] fetch_index_q, fetch_index_d;
    logic               inflight_q, inflight_d;
    logic [INDEX_W-1:0] inflight_index_q, inflight_index_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               head_valid;
    logic               pop;
    logic               push;
    logic               issue;
    logic               take_branch;
    logic [CNT_W:0]     room_check;
    logic [INDEX_W-1:0] branch_target;
    logic [ADDR_W-1:0]  read_addr;
    logic [ADDR_W-1:0]  write_addr;
    logic               unused_addr_hi;

    assign read_addr  = fetch_index_q[ADDR_W-1:0];
    assign write_addr = write_instruction_index[ADDR_W-1:0];

    // Only the low address bits select a memory word; the rest are ignored.
    assign unused_addr_hi = ^write_instruction_index[INDEX_W-1:ADDR_W];

    // Handshake and control decode. Everything here depends on registered
    // state plus the decode-side inputs; nothing feeds back into the outputs.
    always_comb begin
        head_valid    = (count_q != '0);
        pop           = head_valid & out_ready;
        take_branch   = branch_valid & head_valid;
        branch_target = fifo_index[head_q] + delta_i;
        // Occupancy after this edge's pop, counting the read still in flight.
        // A new read is issued only while that leaves a slot free, which is
        // what lets a push always land without a full check.
        room_check    = {1'b0, count_q}
                      + {{CNT_W{1'b0}}, inflight_q}
                      - {{CNT_W{1'b0}}, pop};
        issue         = !take_branch && (room_check < DEPTH_V);
        push          = inflight_q && !take_branch;
    end

    // Next-state for fetch index, in-flight tracking and FIFO pointers.
    // A branch wins over push, pop and issue: the queue and the in-flight
    // read are dropped and fetch restarts at the target on the following edge.
    always_comb begin
        fetch_index_d    = fetch_index_q;
        inflight_d       = inflight_q;
        inflight_index_d = inflight_index_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;

        if (take_branch) begin
            fetch_index_d = branch_target;
            inflight_d    = 1'b0;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                fetch_index_d    = fetch_index_q + 1'b1;
                inflight_index_d = fetch_index_q;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register; reset drops the queue and any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_index_q    <= RESET_INDEX;
            inflight_q       <= 1'b0;
            inflight_index_q <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
        end else begin
            fetch_index_q    <= fetch_index_d;
            inflight_q       <= inflight_d;
            inflight_index_q <= inflight_index_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
        end
    end

    // Memory write and read. Both use the old array contents on the same
    // edge, so a read of the address being written returns the old word.
    // The read data is captured at issue time, which also means a later
    // write never alters an entry that is already in flight.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_addr] <= write_instruction;
        end
        if (issue) begin
            rd_data_q <= mem[read_addr];
        end
    end

    // FIFO payload storage, written by the push of a completed read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[tail_q] <= rd_data_q;
            fifo_index[tail_q] <= inflight_index_q;
        end
    end

    assign out_valid       = head_valid;
    assign out_instruction = head_valid ? fifo_instr[head_q] : '0;
    assign out_index       = head_valid ? fifo_index[head_q] : '0;
    assign count           = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. The stimulus process drives the design and
// pushes every entry decode is expected to accept into a scoreboard queue; a
// separate monitor pops and compares each accepted head entry. The stimulus
// process also checks cycle-exact values such as latency, occupancy and reset.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    typedef struct packed {
        logic [31:0] idx;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_enable;
    logic [31:0] write_instruction_index;
    logic [15:0] write_instruction;
    logic        branch_valid;
    logic [31:0] delta_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instruction;
    logic [31:0] out_index;
    logic [2:0]  count;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    fetch_queue dut (
        .clk                     (clk),
        .rst                     (rst),
        .write_enable            (write_enable),
        .write_instruction_index (write_instruction_index),
        .write_instruction       (write_instruction),
        .branch_valid            (branch_valid),
        .delta_i                 (delta_i),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_instruction         (out_instruction),
        .out_index               (out_index),
        .count                   (count)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t",
                     name, actual, required, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the decode-side controls for one cycle.
    task automatic applyStimulus(input logic ready, input logic br,
                                 input logic [31:0] delta);
        out_ready    = ready;
        branch_valid = br;
        delta_i      = delta;
        tick();
        branch_valid = 1'b0;
        delta_i      = '0;
    endtask

    task automatic writeMem(input logic [31:0] idx, input logic [15:0] data);
        write_enable            = 1'b1;
        write_instruction_index = idx;
        write_instruction       = data;
        tick();
        write_enable            = 1'b0;
    endtask

    task automatic expectPush(input logic [31:0] idx, input logic [15:0] instr);
        exp_t e;
        e.idx   = idx;
        e.instr = instr;
        expq.push_back(e);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_count"}, {29'd0, count}, 32'd0);
        checkOutput({tag, "_instr"}, {16'd0, out_instruction}, 32'd0);
        checkOutput({tag, "_index"}, out_index, 32'd0);
    endtask

    // Monitor: every accepted head entry (valid, ready, no branch that edge)
    // must match the next scoreboard entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready && !branch_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_accept: got index 0x%0h, required none",
                             out_index);
                end else begin
                    e = expq.pop_front();
                    checkOutput("mon_index", out_index, e.idx);
                    checkOutput("mon_instr", {16'd0, out_instruction}, {16'd0, e.instr});
                end
            end
        end
    end

    // Guard against a run that never reaches its end.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        out_ready               = 1'b0;
        branch_valid            = 1'b0;
        delta_i                 = '0;
        write_enable            = 1'b0;
        write_instruction_index = '0;
        write_instruction       = '0;
        rst                     = 1'b1;

        // Load mem[i] = 0x1000 + i while held in reset.
        for (int i = 0; i < 256; i++) begin
            writeMem(i, 16'h1000 + i[15:0]);
        end
        checkReset("reset");

        // Latency and back-to-back streaming of 0..5.
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            expectPush(k, 16'h1000 + k[15:0]);
        end
        for (int k = 0; k < 6; k++) begin
            checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stream_index", out_index, k);
            tick();
        end
        out_ready = 1'b0;
        checkOutput("sb_empty_stream", expq.size(), 32'd0);

        // Stall with decode not ready: occupancy saturates, then drains in order.
        rst = 1'b1;
        tick();
        checkReset("reset2");
        rst = 1'b0;
        repeat (10) tick();
        checkOutput("stall_count", {29'd0, count}, 32'd4);
        checkOutput("stall_head", out_index, 32'd0);
        for (int k = 0; k <= 10; k++) begin
            expectPush(k, 16'h1000 + k[15:0]);
        end
        out_ready = 1'b1;
        repeat (11) tick();
        checkOutput("head_11", out_index, 32'd11);

        // Backward branch from 11 by -2: flush, target 9 after two edges.
        expectPush(32'd9, 16'h1009);
        expectPush(32'd10, 16'h100A);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
        checkOutput("br_flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("br_flush_count", {29'd0, count}, 32'd0);
        tick();
        checkOutput("br_edge1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("br_target_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("br_target_index", out_index, 32'd9);
        checkOutput("br_target_instr", {16'd0, out_instruction}, 32'h1009);
        repeat (2) tick();

        // Branch 11 - 12 = 0xFFFFFFFF, stalled until three entries are queued.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF4);
        repeat (4) tick();
        checkOutput("wrap_count3", {29'd0, count}, 32'd3);
        checkOutput("wrap_head_index", out_index, 32'hFFFF_FFFF);
        checkOutput("wrap_head_instr", {16'd0, out_instruction}, 32'h10FF);

        // Zero-offset branch refetches the head; the next index wraps to 0.
        applyStimulus(1'b0, 1'b1, 32'd0);
        checkOutput("wrap_flush_count", {29'd0, count}, 32'd0);
        repeat (2) tick();
        checkOutput("refetch_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("refetch_index", out_index, 32'hFFFF_FFFF);
        expectPush(32'hFFFF_FFFF, 16'h10FF);
        for (int k = 0; k <= 8; k++) begin
            expectPush(k, 16'h1000 + k[15:0]);
        end
        out_ready = 1'b1;
        repeat (6) tick();
        checkOutput("head_5", out_index, 32'd5);

        // Write index 7 on the edge that issues its read: old data delivered.
        writeMem(32'd7, 16'hBEEF);
        tick();
        checkOutput("old_data_index", out_index, 32'd7);
        checkOutput("old_data_instr", {16'd0, out_instruction}, 32'h1007);
        repeat (2) tick();
        checkOutput("head_9", out_index, 32'd9);

        // Branch back to 7: the new data is fetched this time.
        expectPush(32'd7, 16'hBEEF);
        expectPush(32'd8, 16'h1008);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
        repeat (2) tick();
        checkOutput("new_data_index", out_index, 32'd7);
        checkOutput("new_data_instr", {16'd0, out_instruction}, 32'hBEEF);
        repeat (2) tick();

        // Reset mid-stream with three queued, one in flight and a branch pending.
        out_ready = 1'b0;
        repeat (2) tick();
        checkOutput("pre_reset_count", {29'd0, count}, 32'd3);
        branch_valid = 1'b1;
        delta_i      = 32'd5;
        #2;
        rst = 1'b1;
        #1;
        checkReset("async_reset");
        @(posedge clk);
        #1;
        branch_valid = 1'b0;
        delta_i      = '0;
        rst          = 1'b0;
        out_ready    = 1'b1;
        expectPush(32'd0, 16'h1000);
        expectPush(32'd1, 16'h1001);
        tick();
        checkOutput("restart_edge1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("restart_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("restart_index", out_index, 32'd0);
        checkOutput("restart_instr", {16'd0, out_instruction}, 32'h1000);
        repeat (2) tick();
        out_ready = 1'b0;
        repeat (2) tick();
        checkOutput("sb_drained", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-step fetch/instruction-cache pair.
- Holds the fetch index and a write-loadable instruction memory (same write port semantics as the instruction cache).
- Adds a prefetch FIFO with a valid/ready handshake to decode, plus PC-relative branch redirect with queue flush.
- Sits between the instruction store and decode; sustains one instruction per cycle when decode is always ready.

Parameters:
- INSTR_W, 16, instruction width (Thumb halfword).
- INDEX_W, 32, instruction index width.
- MEM_DEPTH, 256, instruction memory entries; power of two.
- QUEUE_DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_INDEX, 0, fetch index loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- write_enable  in  1  memory write strobe.
- write_instruction_index  in  INDEX_W  write address; low log2(MEM_DEPTH) bits used.
- write_instruction  in  INSTR_W  write data.
- branch_valid  in  1  redirect request, relative to the head entry.
- delta_i  in  INDEX_W  signed branch offset, in instructions.
- out_valid  out  1  head entry present.
- out_ready  in  1  decode accepts the head entry.
- out_instruction  out  INSTR_W  head instruction; 0 when out_valid=0.
- out_index  out  INDEX_W  head instruction index; 0 when out_valid=0.
- count  out  log2(QUEUE_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-fetch or mid-branch):
  - fetch_index = RESET_INDEX; FIFO empty; in-flight read dropped.
  - out_valid = 0, count = 0, out_instruction = 0, out_index = 0.
  - Memory contents are not reset.
- Memory: synchronous write on clk when write_enable=1. Synchronous read with 1-cycle latency. Read of the address being written in the same cycle returns old data. Addresses wrap modulo MEM_DEPTH.
- Issue rule: a read of mem[fetch_index] is issued on an edge when (count + inflight - pop) < QUEUE_DEPTH.
  - pop = out_valid & out_ready; inflight is 0 or 1.
  - On issue, fetch_index += 1 (INDEX_W wrap).
  - The read result is pushed with its index on the next edge.
- Throughput: with out_ready held at 1, one push and one pop per cycle, with no bubbles.
- Latency: out_valid rises after the 2nd rising edge following reset release. Head = mem[RESET_INDEX], out_index = RESET_INDEX.
- Push and pop on the same edge: count is unchanged. Push is never blocked at full, because the issue rule guarantees room.
- Empty FIFO: pop is impossible; out_ready is ignored.
- Branch, taken only when branch_valid=1 and out_valid=1:
  - target = out_index + delta_i (two's complement, INDEX_W wrap).
  - On that edge: FIFO flushed (count = 0), in-flight read discarded, fetch_index = target. Any pop that edge is discarded.
  - Next edge: read of target issued. out_valid rises 2 edges after the branch edge with out_index = target.
  - branch_valid with out_valid=0 is ignored.
- Branch has priority over push and pop on the same edge.
- Coherence: writes do not update entries already in the FIFO or in flight. Only reads issued after the write edge see the new data.
- out_instruction, out_index and count are driven from registered state (FIFO head), with no combinational path from out_ready or branch_valid.

Test Plan:
- Reset release, mem[0..5] = 0x1000..0x1005, out_ready=1 -> out_valid rises after edge 2. Then out_index 0,1,2,3,4,5 on consecutive cycles with matching data, no gaps.
- out_ready=0 for 10 cycles -> count saturates at 4, fetch_index stops at 4. With out_ready=1 again, indices 0..3 drain and then 4,5 follow with no duplicates or skips.
- Head out_index=11, branch_valid=1, delta_i=-2 -> FIFO flushed. Two edges later out_valid=1, out_index=9, out_instruction=mem[9]. Stale 12..14 are never presented.
- Branch with delta_i=0 at out_index=0xFFFFFFFF and count=3 -> refetch from 0xFFFFFFFF, then next index wraps to 0 (memory address 0xFF then 0x00).
- write_enable to index 7 on the same edge as the read issue of 7 -> old data delivered. Branch back to 7 afterwards -> new data delivered.
- Assert rst mid-stream (count=3, read in flight, branch_valid high) -> immediately out_valid=0, count=0. After release, delivery restarts at RESET_INDEX with the 2-edge latency.
